key_lifecycle_ctrl: RTL and testbench
=====================================

Name: key_lifecycle_ctrl

Overview:
Second-generation key-lifecycle sequencer for the PUF key path. It adds a reconstruction mode alongside enrollment:
- Enroll: the fuzzy-extractor generator produces the helper data.
- Reconstruct: the fuzzy-extractor reproducer consumes helper data supplied from NVM.

Other additions: per-phase watchdog timeout, bounded retry on decode failure, abort, key zeroization and a status code. It sits between the system command interface, the fuzzy-extractor engine and the SHA3-512 hash engine. It owns all key/helper output registers.

Parameters:
FE_BLOCKS, 22, number of fuzzy-extractor blocks
N, 32, bits per block; RP_W = FE_BLOCKS*N (704)
KEY_W, 512, derived key width
TIMEOUT_CYC, 4096, max cycles waiting in any *_WAIT state (>=2)
MAX_RETRY, 3, reconstruct re-attempts after fe_fail (0 = none)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE/READY/ERROR
cmd_mode  in  1  0 = enroll, 1 = reconstruct
cmd_abort  in  1  abort current operation
zeroize  in  1  wipe key and helper registers
helper_in  in  RP_W  stored helper data (reconstruct)
fe_start  out  1  one-cycle FE start pulse
fe_mode  out  1  registered cmd_mode
fe_helper  out  RP_W  registered helper_in
fe_done  in  1  FE complete pulse
fe_fail  in  1  decode failure, valid with fe_done
fe_rprime  in  RP_W  FE response
fe_helper_out  in  RP_W  FE-generated helper (enroll)
hash_start  out  1  one-cycle hash start pulse
hash_in  out  RP_W  latched rprime
hash_done  in  1  hash complete pulse
hash_key  in  KEY_W  hash result
key_out  out  KEY_W  derived key
key_valid  out  1  key_out valid
helper_out  out  RP_W  enrollment helper data
helper_valid  out  1  helper_out valid (enroll only)
busy  out  1  ~cmd_ready
status  out  3  0 OK, 1 BUSY, 2 TIMEOUT, 3 DECODE_FAIL, 4 ABORTED, 5 ZEROIZED

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - All data registers, key_out and helper_out are 0.
  - key_valid, helper_valid, fe_start and hash_start are 0.
  - status = 0, retry count = 0, timer = 0.
- States: IDLE, FE_START, FE_WAIT, HASH_START, HASH_WAIT, READY, ERROR.
- Command acceptance:
  - A command is accepted when cmd_valid && cmd_ready.
  - On acceptance, latch cmd_mode and helper_in, clear key_valid, helper_valid and retry count, set status = 1, and go to FE_START.
- FE_START: fe_start = 1 for exactly one cycle, timer cleared, then FE_WAIT.
- FE_WAIT:
  - Timer increments each cycle.
  - fe_done && !fe_fail: latch fe_rprime into hash_in. If mode = 0, also latch fe_helper_out into helper_out and set helper_valid. Go to HASH_START.
  - fe_done && fe_fail, with mode = 1 and retry < MAX_RETRY: increment retry, go to FE_START.
  - fe_done && fe_fail otherwise: status = 3, go to ERROR.
  - A fail in enroll mode goes straight to ERROR (no retry).
- HASH_START: hash_start = 1 for one cycle, timer cleared, then HASH_WAIT.
- HASH_WAIT: on hash_done, latch hash_key into key_out, set key_valid, set status = 0, go to READY.
- Timeout:
  - In FE_WAIT or HASH_WAIT, when the timer reaches TIMEOUT_CYC-1 without a done: status = 2, go to ERROR.
  - A done arriving on that same cycle wins over the timeout.
- Command latency from idle: fe_start is asserted the cycle after acceptance. key_valid rises the cycle after hash_done.
- cmd_abort (ignored in IDLE/READY/ERROR):
  - Takes priority over done/fail/timeout.
  - Go to ERROR with status = 4.
  - Clear key_valid, helper_valid, key_out, helper_out and hash_in.
  - Late fe_done/hash_done pulses are then ignored.
- zeroize:
  - Highest priority, any state.
  - Clear key_out, helper_out, hash_in and the valids.
  - status = 5, go to IDLE.
  - A simultaneous cmd_valid is not accepted that cycle.
- READY and ERROR accept a new command exactly like IDLE. ERROR outputs stay cleared.
- Unexpected fe_done or hash_done outside its WAIT state is ignored.
- The timer is wide enough for TIMEOUT_CYC ($clog2) and saturates; no wrap.

Decomposition:
- Package key_lifecycle_pkg holds:
  - the state enum;
  - status code constants ST_OK, ST_BUSY, ST_TIMEOUT, ST_DECODE_FAIL, ST_ABORTED, ST_ZEROIZED;
  - mode constants MODE_ENROLL and MODE_RECON.
- One sub-module, phase_watchdog: a loadable timeout counter with clear, enable and expired outputs. It is shared by both WAIT states.

Test Plan:
1. Enroll: cmd_mode=0, helper_in ignored; FE done after 100 cycles with rprime=pattern A, hash done 30 cycles later with key K -> helper_valid the cycle after fe_done, key_out=K, key_valid=1, status=0.
2. Reconstruct retry: MAX_RETRY=3; fe_fail on the first two attempts, then success -> exactly 3 fe_start pulses, key_valid=1, helper_valid=0, status=0.
3. Decode failure: 4 consecutive fe_fail in reconstruct -> 4 fe_start pulses, ERROR, status=3, key_valid=0, cmd_ready=1.
4. Timeout: TIMEOUT_CYC=16, hash_done never asserted -> ERROR after 15 HASH_WAIT cycles, status=2; hash_done on cycle 15 instead -> READY.
5. Abort/zeroize: cmd_abort in the same cycle as fe_done -> status=4 and no hash_start. Zeroize in READY -> key_out=0, status=5, IDLE.
6. Async reset mid-HASH_WAIT, rst_n low for less than one clock period -> all outputs 0 immediately; new enroll succeeds afterwards.

Source files
------------

// File: rtl/key_lifecycle_pkg.sv
// Shared types and constants for the PUF key-lifecycle sequencer.
//   state_e      : sequencer state encoding
//   ST_*         : status codes reported on the status port
//   MODE_*       : command mode encoding (enroll / reconstruct)
package key_lifecycle_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFeStart,
    StFeWait,
    StHashStart,
    StHashWait,
    StReady,
    StError
  } state_e;

  localparam logic [2:0] ST_OK          = 3'd0;
  localparam logic [2:0] ST_BUSY        = 3'd1;
  localparam logic [2:0] ST_TIMEOUT     = 3'd2;
  localparam logic [2:0] ST_DECODE_FAIL = 3'd3;
  localparam logic [2:0] ST_ABORTED     = 3'd4;
  localparam logic [2:0] ST_ZEROIZED    = 3'd5;

  localparam logic MODE_ENROLL = 1'b0;
  localparam logic MODE_RECON  = 1'b1;

  // States in which a new command may be accepted.
  function automatic logic is_cmd_state(state_e s);
    return (s == StIdle) || (s == StReady) || (s == StError);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase timeout counter shared by the FE and hash wait phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the counter with zero (entry into a new phase)
//   en         : count one cycle of waiting
//   expired    : the current waiting cycle is the last one allowed (LIMIT-1 cycles)
module phase_watchdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(LIMIT - 1);
  localparam logic [CntW-1:0] CntTrip = CntW'(LIMIT - 2);

  logic [CntW-1:0] count_q, count_d;

  // Saturating count; never wraps back to zero while waiting.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CntMax)) begin
      count_d = count_q + CntW'(1);
    end
  end

  // The counter is about to reach LIMIT-1 on this waiting cycle.
  assign expired = (count_q >= CntTrip);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/key_lifecycle_ctrl.sv
// Key-lifecycle sequencer for the PUF key path: drives the fuzzy extractor (enroll or
// reconstruct with bounded retry) and then the SHA3-512 hash, owning all key/helper outputs.
//   cmd_valid/cmd_ready/cmd_mode/cmd_abort : command interface (mode 0 enroll, 1 reconstruct)
//   zeroize                                : wipe key/helper state, return to idle
//   helper_in                              : NVM helper data for reconstruction
//   fe_start/fe_mode/fe_helper             : fuzzy-extractor request
//   fe_done/fe_fail/fe_rprime/fe_helper_out: fuzzy-extractor response
//   hash_start/hash_in, hash_done/hash_key : hash request / response
//   key_out/key_valid, helper_out/helper_valid : derived key and enrollment helper data
//   busy, status                           : activity flag and status code
module key_lifecycle_ctrl
  import key_lifecycle_pkg::*;
#(
  parameter int unsigned FE_BLOCKS   = 22,
  parameter int unsigned N           = 32,
  parameter int unsigned KEY_W       = 512,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned MAX_RETRY   = 3,
  localparam int unsigned RP_W       = FE_BLOCKS * N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic             cmd_abort,
  input  logic             zeroize,
  input  logic [RP_W-1:0]  helper_in,
  output logic             fe_start,
  output logic             fe_mode,
  output logic [RP_W-1:0]  fe_helper,
  input  logic             fe_done,
  input  logic             fe_fail,
  input  logic [RP_W-1:0]  fe_rprime,
  input  logic [RP_W-1:0]  fe_helper_out,
  output logic             hash_start,
  output logic [RP_W-1:0]  hash_in,
  input  logic             hash_done,
  input  logic [KEY_W-1:0] hash_key,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [RP_W-1:0]  helper_out,
  output logic             helper_valid,
  output logic             busy,
  output logic [2:0]       status
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [RP_W-1:0]    fe_helper_q, fe_helper_d;
  logic [RP_W-1:0]    hash_in_q, hash_in_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               key_valid_q, key_valid_d;
  logic [RP_W-1:0]    helper_q, helper_d;
  logic               helper_valid_q, helper_valid_d;
  logic [2:0]         status_q, status_d;
  logic [RetryW-1:0]  retry_q, retry_d;

  logic wd_clr, wd_en, wd_expired;
  logic wipe;

  phase_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  assign cmd_ready = is_cmd_state(state_q);

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    fe_helper_d    = fe_helper_q;
    hash_in_d      = hash_in_q;
    key_d          = key_q;
    key_valid_d    = key_valid_q;
    helper_d       = helper_q;
    helper_valid_d = helper_valid_q;
    status_d       = status_q;
    retry_d        = retry_q;
    wd_clr         = 1'b0;
    wd_en          = 1'b0;
    wipe           = 1'b0;

    if (zeroize) begin
      // Zeroize beats everything, including a command offered in the same cycle.
      wipe     = 1'b1;
      status_d = ST_ZEROIZED;
      state_d  = StIdle;
    end else if (cmd_abort && !cmd_ready) begin
      wipe     = 1'b1;
      status_d = ST_ABORTED;
      state_d  = StError;
    end else begin
      unique case (state_q)
        StIdle, StReady, StError: begin
          if (cmd_valid) begin
            mode_d         = cmd_mode;
            fe_helper_d    = helper_in;
            key_valid_d    = 1'b0;
            helper_valid_d = 1'b0;
            retry_d        = '0;
            status_d       = ST_BUSY;
            state_d        = StFeStart;
          end
        end
        StFeStart: begin
          wd_clr  = 1'b1;
          state_d = StFeWait;
        end
        StFeWait: begin
          wd_en = 1'b1;
          if (fe_done) begin
            if (!fe_fail) begin
              hash_in_d = fe_rprime;
              if (mode_q == MODE_ENROLL) begin
                helper_d       = fe_helper_out;
                helper_valid_d = 1'b1;
              end
              state_d = StHashStart;
            end else if ((mode_q == MODE_RECON) && (32'(retry_q) < MAX_RETRY)) begin
              retry_d = retry_q + RetryW'(1);
              state_d = StFeStart;
            end else begin
              wipe     = 1'b1;
              status_d = ST_DECODE_FAIL;
              state_d  = StError;
            end
          end else if (wd_expired) begin
            wipe     = 1'b1;
            status_d = ST_TIMEOUT;
            state_d  = StError;
          end
        end
        StHashStart: begin
          wd_clr  = 1'b1;
          state_d = StHashWait;
        end
        StHashWait: begin
          wd_en = 1'b1;
          if (hash_done) begin
            key_d       = hash_key;
            key_valid_d = 1'b1;
            status_d    = ST_OK;
            state_d     = StReady;
          end else if (wd_expired) begin
            wipe     = 1'b1;
            status_d = ST_TIMEOUT;
            state_d  = StError;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Every error/abort/zeroize exit leaves no key material visible.
    if (wipe) begin
      key_d          = '0;
      key_valid_d    = 1'b0;
      helper_d       = '0;
      helper_valid_d = 1'b0;
      hash_in_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      mode_q         <= 1'b0;
      fe_helper_q    <= '0;
      hash_in_q      <= '0;
      key_q          <= '0;
      key_valid_q    <= 1'b0;
      helper_q       <= '0;
      helper_valid_q <= 1'b0;
      status_q       <= ST_OK;
      retry_q        <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      fe_helper_q    <= fe_helper_d;
      hash_in_q      <= hash_in_d;
      key_q          <= key_d;
      key_valid_q    <= key_valid_d;
      helper_q       <= helper_d;
      helper_valid_q <= helper_valid_d;
      status_q       <= status_d;
      retry_q        <= retry_d;
    end
  end

  // Start pulses are state-decoded: each start state lasts exactly one cycle.
  assign fe_start     = (state_q == StFeStart);
  assign hash_start   = (state_q == StHashStart);
  assign fe_mode      = mode_q;
  assign fe_helper    = fe_helper_q;
  assign hash_in      = hash_in_q;
  assign key_out      = key_q;
  assign key_valid    = key_valid_q;
  assign helper_out   = helper_q;
  assign helper_valid = helper_valid_q;
  assign busy         = ~cmd_ready;
  assign status       = status_q;

endmodule

// File: tb/tb_key_lifecycle_ctrl.sv
module tb_key_lifecycle_ctrl;

  localparam int unsigned FE_BLOCKS   = 22;
  localparam int unsigned N           = 32;
  localparam int unsigned RP_W        = FE_BLOCKS * N;
  localparam int unsigned KEY_W       = 512;
  localparam int unsigned TIMEOUT_CYC = 128;
  localparam int unsigned MAX_RETRY   = 3;
  localparam int unsigned CW          = RP_W;
  localparam int          T1          = TIMEOUT_CYC - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_mode = 1'b0;
  logic             cmd_abort = 1'b0;
  logic             zeroize = 1'b0;
  logic [RP_W-1:0]  helper_in = '0;
  logic             fe_start;
  logic             fe_mode;
  logic [RP_W-1:0]  fe_helper;
  logic             fe_done = 1'b0;
  logic             fe_fail = 1'b0;
  logic [RP_W-1:0]  fe_rprime = '0;
  logic [RP_W-1:0]  fe_helper_out = '0;
  logic             hash_start;
  logic [RP_W-1:0]  hash_in;
  logic             hash_done = 1'b0;
  logic [KEY_W-1:0] hash_key = '0;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic [RP_W-1:0]  helper_out;
  logic             helper_valid;
  logic             busy;
  logic [2:0]       status;

  always #5 clk = ~clk;

  key_lifecycle_ctrl #(
    .FE_BLOCKS  (FE_BLOCKS),
    .N          (N),
    .KEY_W      (KEY_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_abort    (cmd_abort),
    .zeroize      (zeroize),
    .helper_in    (helper_in),
    .fe_start     (fe_start),
    .fe_mode      (fe_mode),
    .fe_helper    (fe_helper),
    .fe_done      (fe_done),
    .fe_fail      (fe_fail),
    .fe_rprime    (fe_rprime),
    .fe_helper_out(fe_helper_out),
    .hash_start   (hash_start),
    .hash_in      (hash_in),
    .hash_done    (hash_done),
    .hash_key     (hash_key),
    .key_out      (key_out),
    .key_valid    (key_valid),
    .helper_out   (helper_out),
    .helper_valid (helper_valid),
    .busy         (busy),
    .status       (status)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state carried between operations.
  logic [KEY_W-1:0] exp_key    = '0;
  logic [RP_W-1:0]  exp_helper = '0;
  logic [RP_W-1:0]  exp_hash   = '0;

  task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RP_W-1:0] rand_rp();
    logic [RP_W-1:0] v;
    for (int i = 0; i < int'(RP_W / 32); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [KEY_W-1:0] rand_key();
    logic [KEY_W-1:0] v;
    for (int i = 0; i < int'(KEY_W / 32); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // One command: FE answers fe_dly cycles after each fe_start (attempt k fails while
  // k <= n_fail), hash answers hash_dly cycles after hash_start (0 = never), and
  // cmd_abort is raised on cycle abort_cyc (-1 = never). Cycle 0 is the fe_start cycle.
  task automatic run_txn(input bit mode, input int n_fail, input int fe_dly,
                         input int hash_dly, input int abort_cyc);
    int exp_st, d, d_fe, p, n_att, exp_hs;
    bit fail, fe_ok_path;
    int cyc, fe_at, hs_at, att, hs_cnt, ready_cyc;
    bit hv_chk;
    logic [RP_W-1:0] hin, rp, hl, rp_ok, hl_ok;
    logic [KEY_W-1:0] k, k_ok;

    // Expected outcome from the timing rules alone.
    p = fe_dly + 1;
    fe_ok_path = 0;
    d_fe = 0;
    fail = 0;
    n_att = 1;
    if (fe_dly > T1) begin
      exp_st = 2;
      d = T1;
    end else begin
      if (mode == 1'b0) begin
        n_att = 1;
        fail = (n_fail > 0);
      end else begin
        n_att = ((n_fail < int'(MAX_RETRY)) ? n_fail : int'(MAX_RETRY)) + 1;
        fail = (n_fail > int'(MAX_RETRY));
      end
      d_fe = n_att * p - 1;
      if (fail) begin
        exp_st = 3;
        d = d_fe;
      end else begin
        fe_ok_path = 1;
        if (hash_dly == 0 || hash_dly > T1) begin
          exp_st = 2;
          d = d_fe + 1 + T1;
        end else begin
          exp_st = 0;
          d = d_fe + 1 + hash_dly;
        end
      end
    end
    exp_hs = fe_ok_path ? 1 : 0;
    if (abort_cyc >= 0 && abort_cyc <= d) begin
      exp_st = 4;
      d = abort_cyc;
      if (fe_dly <= T1 && (abort_cyc / p + 1) < n_att) n_att = abort_cyc / p + 1;
      exp_hs = (fe_ok_path && abort_cyc >= d_fe + 1) ? 1 : 0;
    end

    // Drive the command.
    @(negedge clk);
    hin = rand_rp();
    cmd_mode = mode;
    helper_in = hin;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    helper_in = rand_rp();
    check_eq("fe_mode", CW'(fe_mode), CW'(mode));
    check_eq("fe_helper", fe_helper, hin);
    check_eq("status_busy", CW'(status), CW'(1));
    check_eq("busy", CW'(busy), CW'(1));

    cyc = 0; fe_at = -1; hs_at = -1; att = 0; hs_cnt = 0; ready_cyc = -1; hv_chk = 0;
    rp_ok = '0; hl_ok = '0; k_ok = '0;
    while (cyc < 2000) begin
      if (cmd_ready) begin
        ready_cyc = cyc;
        break;
      end
      if (hv_chk) check_eq("helper_valid_lat", CW'(helper_valid), CW'(1));
      hv_chk = 0;
      fe_done = 1'b0;
      hash_done = 1'b0;
      cmd_abort = 1'b0;
      fe_fail = ($urandom() % 2) == 1;
      if (fe_start) begin
        att++;
        fe_at = cyc + fe_dly;
      end
      if (hash_start) begin
        hs_cnt++;
        hs_at = (hash_dly > 0) ? cyc + hash_dly : -1;
      end
      if (cyc == fe_at) begin
        rp = rand_rp();
        hl = rand_rp();
        fe_done = 1'b1;
        fe_fail = (att <= n_fail);
        fe_rprime = rp;
        fe_helper_out = hl;
        if (!fe_fail) begin
          rp_ok = rp;
          hl_ok = hl;
          hv_chk = (mode == 1'b0) && (cyc != abort_cyc);
        end
      end else begin
        fe_rprime = rand_rp();
        fe_helper_out = rand_rp();
      end
      if (cyc == hs_at) begin
        k = rand_key();
        hash_key = k;
        hash_done = 1'b1;
        k_ok = k;
      end else begin
        hash_key = rand_key();
      end
      if (cyc == abort_cyc) cmd_abort = 1'b1;
      @(negedge clk);
      cyc++;
    end
    fe_done = 1'b0;
    hash_done = 1'b0;
    cmd_abort = 1'b0;

    if (exp_st == 0) begin
      exp_key = k_ok;
      exp_hash = rp_ok;
      if (mode == 1'b0) exp_helper = hl_ok;
    end else begin
      exp_key = '0;
      exp_hash = '0;
      exp_helper = '0;
    end
    check_eq("ready_cycle", CW'(ready_cyc), CW'(d + 1));
    check_eq("status", CW'(status), CW'(exp_st));
    check_eq("fe_starts", CW'(att), CW'(n_att));
    check_eq("hash_starts", CW'(hs_cnt), CW'(exp_hs));
    check_eq("key_valid", CW'(key_valid), CW'(exp_st == 0));
    check_eq("helper_valid", CW'(helper_valid), CW'(exp_st == 0 && mode == 1'b0));
    check_eq("key_out", CW'(key_out), CW'(exp_key));
    check_eq("helper_out", helper_out, exp_helper);
    check_eq("hash_in", hash_in, exp_hash);
    check_eq("busy_end", CW'(busy), CW'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit m;
    int nf, fd, hd, ac;

    // Reset state
    #1;
    check_eq("rst_status", CW'(status), CW'(0));
    check_eq("rst_cmd_ready", CW'(cmd_ready), CW'(1));
    check_eq("rst_fe_start", CW'(fe_start), CW'(0));
    check_eq("rst_key_valid", CW'(key_valid), CW'(0));
    check_eq("rst_hash_in", hash_in, CW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Enroll with long FE latency, then a reconstruct needing two retries
    run_txn(1'b0, 0, 100, 30, -1);
    run_txn(1'b1, 2, 10, 5, -1);

    // Stray hash_done and abort while READY are ignored
    @(negedge clk);
    hash_done = 1'b1;
    cmd_abort = 1'b1;
    hash_key = rand_key();
    @(negedge clk);
    hash_done = 1'b0;
    cmd_abort = 1'b0;
    check_eq("ready_stray_key", CW'(key_out), CW'(exp_key));
    check_eq("ready_stray_status", CW'(status), CW'(0));
    check_eq("ready_stray_valid", CW'(key_valid), CW'(1));

    // Decode failures, timeouts and their boundary cycles
    run_txn(1'b1, 4, 7, 5, -1);
    run_txn(1'b0, 1, 5, 5, -1);
    run_txn(1'b0, 0, 3, 0, -1);
    run_txn(1'b0, 0, 3, T1, -1);
    run_txn(1'b1, 0, T1, 4, -1);
    run_txn(1'b1, 0, T1 + 1, 4, -1);

    // Abort on the fe_done cycle, then a fresh enroll and zeroize in READY
    run_txn(1'b0, 0, 20, 5, 20);
    run_txn(1'b0, 0, 4, 6, -1);
    @(negedge clk);
    zeroize = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    cmd_valid = 1'b0;
    exp_key = '0; exp_helper = '0; exp_hash = '0;
    check_eq("zero_status", CW'(status), CW'(5));
    check_eq("zero_key", CW'(key_out), CW'(0));
    check_eq("zero_helper", helper_out, CW'(0));
    check_eq("zero_key_valid", CW'(key_valid), CW'(0));
    check_eq("zero_ready", CW'(cmd_ready), CW'(1));
    check_eq("zero_no_accept", CW'(fe_start), CW'(0));

    // Zeroize mid FE_WAIT, then a late fe_done must be ignored
    @(negedge clk);
    cmd_mode = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    fe_done = 1'b1;
    fe_fail = 1'b0;
    fe_helper_out = rand_rp();
    @(negedge clk);
    fe_done = 1'b0;
    @(negedge clk);
    check_eq("zero_mid_status", CW'(status), CW'(5));
    check_eq("zero_mid_hv", CW'(helper_valid), CW'(0));
    check_eq("zero_mid_ready", CW'(cmd_ready), CW'(1));

    // Async reset mid HASH_WAIT, shorter than a clock period
    @(negedge clk);
    cmd_mode = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    fe_done = 1'b1;
    fe_fail = 1'b0;
    fe_rprime = rand_rp();
    fe_helper_out = rand_rp();
    @(negedge clk);
    fe_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_hv", CW'(helper_valid), CW'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_hash_in", hash_in, CW'(0));
    check_eq("arst_helper_out", helper_out, CW'(0));
    check_eq("arst_hv", CW'(helper_valid), CW'(0));
    check_eq("arst_busy", CW'(busy), CW'(0));
    check_eq("arst_status", CW'(status), CW'(0));
    #2 rst_n = 1'b1;
    exp_key = '0; exp_helper = '0; exp_hash = '0;
    run_txn(1'b0, 0, 4, 4, -1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      m  = ($urandom() % 2) == 1;
      nf = m ? int'($urandom_range(0, 5)) : ((($urandom() % 4) == 0) ? 1 : 0);
      fd = (($urandom() % 10) == 0) ? T1 + 1 : int'($urandom_range(1, 12));
      hd = (($urandom() % 10) == 0) ? 0 : int'($urandom_range(1, 12));
      ac = (($urandom() % 5) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_txn(m, nf, fd, hd, ac);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
